// File: rtl/hien_thi_7doan.sv
// Six-digit multiplexed 7-segment driver (common anode, active-low) with field blink.
// Optional macro DISPLAY_GHOST_BLANK_EN adds an anode-off guard after each digit switch.
module hien_thi_7doan #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLINK_HZ     = 2,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] giay,
  input  logic [7:0] phut,
  input  logic [7:0] gio,
  input  logic [1:0] edit_field,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned BW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] DWELL_M1 = PW'(DWELL - 1);
  localparam logic [BW-1:0] HALF_M1  = BW'(HALF - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [1:0]    edit_q, edit_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          scan_tick;
  logic [3:0]    nib;
  logic [6:0]    seg_raw;
  logic          blank;
  logic [5:0]    an_onehot;

  always_comb begin
    scan_tick   = (pre_q == DWELL_M1);
    pre_d       = scan_tick ? '0 : pre_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (scan_tick) digit_idx_d = (digit_idx_q == 3'd5) ? 3'd0 : digit_idx_q + 3'd1;

    // An edit_field change restarts the blink phase lit so the field is visible at once.
    edit_d      = edit_field;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_on_d  = blink_on_q;
    if (edit_field != edit_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == HALF_M1) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end

    case (digit_idx_q)
      3'd0:    nib = giay[3:0];
      3'd1:    nib = giay[7:4];
      3'd2:    nib = phut[3:0];
      3'd3:    nib = phut[7:4];
      3'd4:    nib = gio[3:0];
      default: nib = gio[7:4];
    endcase

    case (nib)
      4'd0:    seg_raw = 7'b1000000;
      4'd1:    seg_raw = 7'b1111001;
      4'd2:    seg_raw = 7'b0100100;
      4'd3:    seg_raw = 7'b0110000;
      4'd4:    seg_raw = 7'b0011001;
      4'd5:    seg_raw = 7'b0010010;
      4'd6:    seg_raw = 7'b0000010;
      4'd7:    seg_raw = 7'b1111000;
      4'd8:    seg_raw = 7'b0000000;
      4'd9:    seg_raw = 7'b0010000;
      default: seg_raw = 7'b0111111;
    endcase

    blank     = !blink_on_q && ({1'b0, edit_field} == ({1'b0, digit_idx_q[2:1]} + 3'd1));
    seg_d     = blank ? 7'b1111111 : seg_raw;
    dp_d      = ~(blink_on_q && (digit_idx_q == 3'd2 || digit_idx_q == 3'd4));
    an_onehot = ~(6'b000001 << digit_idx_q);
`ifdef DISPLAY_GHOST_BLANK_EN
    an_d      = (32'(pre_q) < BLANK_CYCLES) ? 6'b111111 : an_onehot;
`else
    an_d      = an_onehot;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q       <= '0;
      digit_idx_q <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      edit_q      <= '0;
      an_q        <= 6'b111111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      pre_q       <= pre_d;
      digit_idx_q <= digit_idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      edit_q      <= edit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_hien_thi_7doan.sv
// Scoreboard bench for hien_thi_7doan: a cycle model queues expected {an,seg,dp} per edge.
module tb_hien_thi_7doan;

  localparam int CLK_HZ = 1000, SCAN_HZ = 100, BLINK_HZ = 10, BLANK_CYCLES = 4;
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] giay = '0, phut = '0, gio = '0;
  logic [1:0] edit_field = '0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  hien_thi_7doan #(
    .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .giay(giay), .phut(phut), .gio(gio),
    .edit_field(edit_field), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];

  int m_pre, m_idx, m_bc, m_edit;
  bit m_blink;
  logic [6:0] dec_tab [16];

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_bc = 0; m_blink = 1'b1; m_edit = 0;
  endtask

  function automatic logic [13:0] model_out();
    logic [3:0] n;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    case (m_idx)
      0: n = giay[3:0];
      1: n = giay[7:4];
      2: n = phut[3:0];
      3: n = phut[7:4];
      4: n = gio[3:0];
      default: n = gio[7:4];
    endcase
    e_seg = dec_tab[n];
    if (!m_blink && (m_idx / 2 + 1 == int'(edit_field))) e_seg = 7'b1111111;
    e_dp = !(m_blink && (m_idx == 2 || m_idx == 4));
    e_an = 6'b111111;
    e_an[m_idx] = 1'b0;
`ifdef DISPLAY_GHOST_BLANK_EN
    if (m_pre < BLANK_CYCLES) e_an = 6'b111111;
`endif
    return {e_an, e_seg, e_dp};
  endfunction

  task automatic model_adv();
    if (m_pre == DWELL - 1) begin
      m_pre = 0;
      m_idx = (m_idx + 1) % 6;
    end else m_pre++;
    if (int'(edit_field) != m_edit) begin
      m_bc = 0; m_blink = 1'b1;
    end else if (m_bc == HALF - 1) begin
      m_bc = 0; m_blink = !m_blink;
    end else m_bc++;
    m_edit = int'(edit_field);
  endtask

  task automatic step(input string tag);
    exp_q.push_back(model_out());
    model_adv();
    @(posedge clk); #1;
    chk(tag, {an, seg, dp}, exp_q.pop_front());
  endtask

  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001; dec_tab[2] = 7'b0100100;
    dec_tab[3] = 7'b0110000; dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
    dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000; dec_tab[8] = 7'b0000000;
    dec_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {8'h0, an}, 14'h003F);
    chk("rst_seg", {7'h0, seg}, 14'h007F);
    chk("rst_dp", {13'h0, dp}, 14'h0001);

    gio = 8'h23; phut = 8'h45; giay = 8'h59; edit_field = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("scan_first");
`ifndef DISPLAY_GHOST_BLANK_EN
    chk("first_an", {8'h0, an}, {8'h0, 6'b111110});
    chk("first_seg", {7'h0, seg}, {7'h0, 7'b0010000});
`endif
    run("scan", 6 * DWELL * 2 + 5);

    giay = 8'h5A;
    run("bad_nib", 6 * DWELL + 3);

    giay = 8'h37; edit_field = 2'd2;
    run("edit_min", 2 * HALF + 20);

    edit_field = 2'd0;
    begin
      int k;
      for (k = 0; k < 3 * HALF && m_bc != HALF - 1; k++) step("wait_wrap");
      chk("found_wrap", {13'h0, (m_bc == HALF - 1)}, 14'h0001);
    end
    edit_field = 2'd3;
    run("edit_hr", HALF + 20);

    begin
      int k;
      for (k = 0; k < 8 * DWELL && !(m_idx == 3 && m_pre == 5); k++) step("wait_d3");
      chk("found_d3", {13'h0, (m_idx == 3 && m_pre == 5)}, 14'h0001);
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_an", {8'h0, an}, 14'h003F);
    chk("arst_seg", {7'h0, seg}, 14'h007F);
    chk("arst_dp", {13'h0, dp}, 14'h0001);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run("after_rst", 6 * DWELL + 10);

    chk("queue_empty", 14'(exp_q.size()), 14'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
